// File: rtl/mem_reg_pkg.sv
// mem_reg_pkg: shared types and defaults for the single-register memory port
// sequencer. Holds the sequencer state encoding, the command op encodings and
// the default data / error-counter widths.
package mem_reg_pkg;

    localparam int unsigned DEFAULT_DW  = 8;
    localparam int unsigned DEFAULT_ECW = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        CHK  = 3'd2,
        RD   = 3'd3,
        RSP  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_reg_master_if.sv
// mem_reg_master_if: command and response valid/ready channels between a
// host and mem_reg_master.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command channel (host -> sequencer)
//   rsp_valid/rsp_ready/rsp_data/rsp_err : response channel (sequencer -> host)
// Modports: master = host side, slave = sequencer side.
interface mem_reg_master_if #(
    parameter int unsigned DW = mem_reg_pkg::DEFAULT_DW
);

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones maximum.
// Ports: clk, rst (synchronous, active-high), inc (count enable), cnt (value).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_reg_master.sv
// mem_reg_master: initiator-side sequencer for the single-register write/read
// port. Accepts one command at a time, drives the register's wr/wdata, samples
// rdata and returns one response per command.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : command / response valid-ready channels
//   reg_wr          : register write strobe, high exactly in WR
//   reg_wdata       : register write data, held outside WR
//   reg_rdata       : register read data (valid while reg_wr = 0)
//   err_cnt         : saturating read-back mismatch count
// Config: MEM_REG_MASTER_READBACK_CHECK_EN adds a CHK read-back cycle after
// every write, with live rsp_err and err_cnt; otherwise both are tied to 0.
module mem_reg_master
    import mem_reg_pkg::*;
#(
    parameter int unsigned DW  = DEFAULT_DW,
    parameter int unsigned ECW = DEFAULT_ECW
) (
    input  logic           clk,
    input  logic           rst,
    mem_reg_master_if.slave bus,
    output logic           reg_wr,
    output logic [DW-1:0]  reg_wdata,
    input  logic [DW-1:0]  reg_rdata,
    output logic [ECW-1:0] err_cnt
);

    state_t        state_q, state_d;
    logic          cmd_ready_q;
    logic          rsp_valid_q;
    logic          reg_wr_q;
    logic [DW-1:0] reg_wdata_q, reg_wdata_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

`ifdef MEM_REG_MASTER_READBACK_CHECK_EN
    logic          rsp_err_q, rsp_err_d;
    logic          mismatch_c;

    // Read-back compare against the data just written (reg_wdata still holds it).
    assign mismatch_c = (state_q == CHK) && (reg_rdata != reg_wdata_q);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next register-output values.
    always_comb begin
        state_d     = state_q;
        reg_wdata_d = reg_wdata_q;
        rsp_data_d  = rsp_data_q;
`ifdef MEM_REG_MASTER_READBACK_CHECK_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    if (bus.cmd_op == OP_WRITE) begin
                        state_d     = WR;
                        reg_wdata_d = bus.cmd_data;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
`ifdef MEM_REG_MASTER_READBACK_CHECK_EN
                state_d    = CHK;
`else
                state_d    = RSP;
                rsp_data_d = reg_wdata_q;
`endif
            end
`ifdef MEM_REG_MASTER_READBACK_CHECK_EN
            CHK: begin
                state_d    = RSP;
                rsp_data_d = reg_rdata;
                rsp_err_d  = mismatch_c;
            end
`endif
            RD: begin
                state_d    = RSP;
                rsp_data_d = reg_rdata;
`ifdef MEM_REG_MASTER_READBACK_CHECK_EN
                rsp_err_d  = 1'b0;
`endif
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake/strobe outputs are registered copies of the next-state decode,
    // so each equals a decode of the state register with no input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_wdata_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            cmd_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RSP);
            reg_wr_q    <= (state_d == WR);
            reg_wdata_q <= reg_wdata_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef MEM_REG_MASTER_READBACK_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    sat_counter #(
        .W (ECW)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mismatch_c),
        .cnt (err_cnt)
    );

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
    assign err_cnt     = '0;
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign reg_wr        = reg_wr_q;
    assign reg_wdata     = reg_wdata_q;

endmodule

// File: tb/tb_mem_reg_master.sv
// tb_mem_reg_master: self-checking bench for mem_reg_master with a behavioural
// 8-bit register model on the reg_* port. Table-driven command vectors feed a
// response scoreboard; hand-written sequences cover reset, backpressure,
// forced read-back mismatches, reset mid-write and back-to-back latency.
module tb_mem_reg_master;
    import mem_reg_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned ECW = 8;
`ifdef MEM_REG_MASTER_READBACK_CHECK_EN
    localparam logic CHK_EN = 1'b1;
    localparam int   PERIOD = 4;
`else
    localparam logic CHK_EN = 1'b0;
    localparam int   PERIOD = 3;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           reg_wr;
    logic [DW-1:0]  reg_wdata;
    logic [DW-1:0]  reg_rdata;
    logic [DW-1:0]  reg_q;
    logic [ECW-1:0] err_cnt;
    logic           force_zero = 1'b0;

    always #5 clk = ~clk;

    mem_reg_master_if #(.DW(DW)) bus ();

    mem_reg_master #(
        .DW  (DW),
        .ECW (ECW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .err_cnt   (err_cnt)
    );

    // Storage register model; force_zero corrupts the read path only.
    always @(posedge clk) begin
        if (rst) begin
            reg_q <= '0;
        end else if (reg_wr) begin
            reg_q <= reg_wdata;
        end
    end
    assign reg_rdata = force_zero ? 8'h00 : reg_q;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } rsp_t;

    typedef struct {
        logic       op;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    rsp_t sb[$];
    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   wr_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // One clock: sample at the falling edge, drive inputs for the next rising
    // edge, and score the handshakes that edge will complete.
    task automatic cycle(input logic v, input logic op, input logic [7:0] d,
                         input logic [7:0] ed, input logic ee, input logic rr,
                         output logic acc);
        rsp_t e;
        @(negedge clk);
        cyc++;
        if (reg_wr) wr_cycles++;
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.rsp_ready = rr;
        acc = v && bus.cmd_ready;
        if (acc) sb.push_back('{data: ed, err: ee});
        if (bus.rsp_valid && rr) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got response %02h, none expected (cycle %0d)",
                         bus.rsp_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
    endtask

    task automatic issue(input logic op, input logic [7:0] d, input logic [7:0] ed,
                         input logic ee, input bit check_wr);
        logic acc;
        logic dummy;
        int   n;
        acc = 1'b0;
        wr_cycles = 0;
        n = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, op, d, ed, ee, 1'b1, acc);
            n++;
        end
        if (!acc) fail_now("cmd_accept");
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            cycle(1'b0, op, d, ed, ee, 1'b1, dummy);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("rsp_wait");
            sb.delete();
        end
        if (check_wr) chk("reg_wr_cycles", 32'(wr_cycles), (op == OP_WRITE) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic       acc;
        logic [7:0] held;
        logic [7:0] d;
        int         n;
        int         idx;
        int         acc_cyc[3];

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_READ;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;

        vecs[0] = '{OP_WRITE, 8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{OP_READ,  8'h00, 8'hA5, 1'b0};
        vecs[2] = '{OP_WRITE, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{OP_READ,  8'hFF, 8'h00, 1'b0};
        vecs[4] = '{OP_WRITE, 8'hFF, 8'hFF, 1'b0};
        vecs[5] = '{OP_READ,  8'h11, 8'hFF, 1'b0};
        vecs[6] = '{OP_WRITE, 8'h5A, 8'h5A, 1'b0};
        vecs[7] = '{OP_READ,  8'h00, 8'h5A, 1'b0};
        vecs[8] = '{OP_READ,  8'h00, 8'h5A, 1'b0};
        vecs[9] = '{OP_WRITE, 8'hC3, 8'hC3, 1'b0};

        // Reset: everything zero while asserted, command presented is dropped.
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_reg_wr", 32'(reg_wr), 32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_WRITE;
        bus.cmd_data  = 8'h55;
        @(negedge clk);
        chk("rst_cmd_ready_2", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        cyc++;
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_rst_reg", 32'(reg_q), 32'd0);

        // Table-driven write/read traffic.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].data, vecs[i].exp_data, vecs[i].exp_err, 1'b1);
            if (i == 1) chk("reg_holds_a5", 32'(reg_q), 32'hA5);
        end

        // Backpressure on a read response.
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, OP_READ, 8'h00, 8'hC3, 1'b0, 1'b0, acc);
            n++;
        end
        if (!acc) fail_now("bp_accept");
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            cycle(1'b0, OP_READ, 8'h00, 8'h00, 1'b0, 1'b0, acc);
            n++;
        end
        if (!bus.rsp_valid) fail_now("bp_rsp_valid");
        held = bus.rsp_data;
        chk("bp_data_value", 32'(held), 32'hC3);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, OP_WRITE, 8'h99, 8'h99, 1'b0, 1'b0, acc);
            chk("bp_rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_data_hold", 32'(bus.rsp_data), 32'(held));
            chk("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
            chk("bp_no_accept", 32'(acc), 32'd0);
        end
        cycle(1'b0, OP_READ, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        @(negedge clk);
        cyc++;
        chk("bp_rsp_done", 32'(bus.rsp_valid), 32'd0);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Forced read-back mismatches.
        force_zero = 1'b1;
        for (int k = 0; k < 300; k++) begin
            issue(OP_WRITE, 8'h3C, CHK_EN ? 8'h00 : 8'h3C, CHK_EN, 1'b0);
            if (k == 0) chk("err_cnt_one", 32'(err_cnt), CHK_EN ? 32'd1 : 32'd0);
        end
        chk("err_cnt_sat", 32'(err_cnt), CHK_EN ? 32'd255 : 32'd0);
        force_zero = 1'b0;
        chk("reg_after_forced", 32'(reg_q), 32'h3C);

        // Reset asserted during WR aborts the write.
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, OP_WRITE, 8'h77, 8'h77, 1'b0, 1'b1, acc);
            n++;
        end
        if (!acc) fail_now("midrst_accept");
        @(negedge clk);
        cyc++;
        bus.cmd_valid = 1'b0;
        chk("midrst_in_wr", 32'(reg_wr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        cyc++;
        chk("midrst_reg_wr", 32'(reg_wr), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_reg", 32'(reg_q), 32'd0);
        chk("midrst_reg_wdata", 32'(reg_wdata), 32'd0);
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        cyc++;
        chk("midrst_idle", 32'(bus.cmd_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, OP_READ, 8'h00, 8'h00, 1'b0, 1'b1, acc);
            chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("midrst_reg_final", 32'(reg_q), 32'd0);

        // Back-to-back writes with continuous valid/ready.
        idx = 0;
        n = 0;
        while ((idx < 3 || sb.size() != 0) && n < 40) begin
            d = 8'(idx + 1);
            cycle(idx < 3, OP_WRITE, d, d, 1'b0, 1'b1, acc);
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            n++;
        end
        if (idx < 3 || sb.size() != 0) begin
            fail_now("b2b_complete");
        end else begin
            chk("b2b_period_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(PERIOD));
            chk("b2b_period_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(PERIOD));
        end
        chk("b2b_reg_final", 32'(reg_q), 32'h03);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
